// File: rtl/ov7670_config_seq.sv
// OV7670 register-init sequencer: walks the config ROM and turns each entry into one SCCB write.
// 16'hFFFF ends the table, 16'hFFF0 inserts a settle delay of DELAY_CYCLES clocks.
module ov7670_config_seq #(
    parameter int          DELAY_CYCLES = 250000,
    parameter logic [7:0]  SCCB_ID      = 8'h42
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    input  logic        sccb_ready,
    output logic        sccb_start,
    output logic [7:0]  sccb_id,
    output logic [7:0]  sccb_reg,
    output logic [7:0]  sccb_data,
    output logic        busy,
    output logic        done,
    output logic [7:0]  wr_count
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_ISSUE,
        S_WAIT_ACC,
        S_WAIT_CMP,
        S_DELAY,
        S_NEXT,
        S_DONE
    } state_e;

    localparam logic [15:0] ENTRY_END   = 16'hFFFF;
    localparam logic [15:0] ENTRY_DELAY = 16'hFFF0;
    localparam logic [7:0]  LAST_ADDR   = 8'hFF;
    localparam logic [7:0]  COUNT_MAX   = 8'hFF;
    localparam int          CNT_W       = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DELAY_CYCLES - 1);

    state_e           state_q, state_d;
    logic [7:0]       rom_addr_q, rom_addr_d;
    logic [7:0]       reg_q, reg_d;
    logic [7:0]       data_q, data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [7:0]       wr_count_q, wr_count_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sccb_start_c;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default before the case; a path
    // that leaves it unassigned would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                if (rom_data == ENTRY_END)        state_d = S_DONE;
                else if (rom_data == ENTRY_DELAY) state_d = S_DELAY;
                else                              state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (sccb_ready) state_d = S_WAIT_ACC;
            end
            S_WAIT_ACC: begin
                if (!sccb_ready) state_d = S_WAIT_CMP;
            end
            S_WAIT_CMP: begin
                if (sccb_ready) state_d = S_NEXT;
            end
            S_DELAY: begin
                if (cnt_q == '0) state_d = S_NEXT;
            end
            S_NEXT: begin
                if (rom_addr_q == LAST_ADDR) state_d = S_DONE;
                else                         state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath updates and the sccb_start strobe, decoded from the current state.
    always_comb begin
        rom_addr_d   = rom_addr_q;
        reg_d        = reg_q;
        data_d       = data_q;
        busy_d       = busy_q;
        done_d       = done_q;
        wr_count_d   = wr_count_q;
        cnt_d        = cnt_q;
        sccb_start_c = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    rom_addr_d = '0;
                    wr_count_d = '0;
                    done_d     = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            S_LATCH: begin
                if (rom_data == ENTRY_END) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end else if (rom_data == ENTRY_DELAY) begin
                    cnt_d = CNT_LOAD;
                end else begin
                    reg_d  = rom_data[15:8];
                    data_d = rom_data[7:0];
                end
            end
            S_ISSUE: begin
                // Strobe is combinational on sccb_ready so it lasts exactly the accepting cycle.
                if (sccb_ready) begin
                    sccb_start_c = 1'b1;
                    if (wr_count_q != COUNT_MAX) wr_count_d = wr_count_q + 8'd1;
                end
            end
            S_DELAY: begin
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            end
            S_NEXT: begin
                if (rom_addr_q == LAST_ADDR) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end else begin
                    rom_addr_d = rom_addr_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr_q <= '0;
            reg_q      <= '0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_count_q <= '0;
            cnt_q      <= '0;
        end else begin
            rom_addr_q <= rom_addr_d;
            reg_q      <= reg_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wr_count_q <= wr_count_d;
            cnt_q      <= cnt_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign sccb_start = sccb_start_c;
    assign sccb_id    = SCCB_ID;
    assign sccb_reg   = reg_q;
    assign sccb_data  = data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign wr_count   = wr_count_q;

endmodule

// File: doc/ov7670_config_seq.md
Name: ov7670_config_seq

Overview:
Configuration sequencer that reads the OV7670 register-init ROM and turns each 16-bit entry into one SCCB register write for the SCCB master. Each ROM entry is {reg_addr[15:8], reg_data[7:0]}. 16'hFFFF marks the end of the table and 16'hFFF0 requests a settle delay, for example after a soft reset. The block sits between the config ROM and the SCCB transmitter and reports completion to the camera-capture top level.

Parameters:
DELAY_CYCLES, 250000, clk cycles spent in a FFF0 delay entry (10 ms at 25 MHz); must be >= 1.
SCCB_ID, 8'h42, OV7670 SCCB write device address driven on sccb_id.

Ports:
clk  in  1  system clock, all logic on posedge.
rst  in  1  asynchronous, active-high reset.
start  in  1  single-cycle request to run the table from address 0.
rom_addr  out  8  address to config ROM.
rom_data  in  16  ROM output, registered in the ROM: valid one clk after rom_addr changes.
sccb_ready  in  1  SCCB master idle (1) / transferring (0).
sccb_start  out  1  one-cycle write request to the SCCB master.
sccb_id  out  8  device address, constant SCCB_ID.
sccb_reg  out  8  register address for the write.
sccb_data  out  8  register value for the write.
busy  out  1  high from accepted start until done.
done  out  1  high when the table has completed; held until next start or reset.
wr_count  out  8  number of SCCB writes issued in the current run.

Behaviour:
- Reset values: rom_addr=0, sccb_start=0, sccb_reg=0, sccb_data=0, busy=0, done=0, wr_count=0, delay counter=0, state=IDLE.
- sccb_id = SCCB_ID at all times, including during reset.
- States: IDLE, FETCH, LATCH, ISSUE, WAIT_ACC, WAIT_CMP, DELAY, NEXT, DONE.
- IDLE / DONE + start=1: rom_addr<=0, wr_count<=0, done<=0, busy<=1, go to FETCH.
- FETCH: one wait cycle covering ROM latency, then go to LATCH.
- LATCH: sample rom_data.
  - 16'hFFFF -> DONE: busy<=0, done<=1.
  - 16'hFFF0 -> DELAY: load counter with DELAY_CYCLES-1.
  - Any other value -> sccb_reg<=rom_data[15:8], sccb_data<=rom_data[7:0], go to ISSUE.
- ISSUE: wait for sccb_ready=1, then pulse sccb_start for exactly one cycle, wr_count<=wr_count+1, go to WAIT_ACC.
- WAIT_ACC: wait for sccb_ready=0 (master accepted). Then go to WAIT_CMP.
- WAIT_CMP: wait for sccb_ready=1 (write finished). Then go to NEXT.
- sccb_reg and sccb_data are held stable from LATCH until the following LATCH.
- DELAY: decrement the counter each cycle; at 0 go to NEXT. DELAY lasts exactly DELAY_CYCLES cycles.
- NEXT:
  - rom_addr=255 -> DONE (the table ends at address 255 even without FFFF; no wrap to 0).
  - Otherwise rom_addr<=rom_addr+1, go to FETCH.
- Back-to-back timing: with sccb_ready already high, a new sccb_start occurs 4 cycles after the previous write completes (NEXT, FETCH, LATCH, ISSUE).
- start while busy=1 is ignored; the table is not restarted.
- start in DONE restarts the table from address 0.
- wr_count saturates at 255.
- Reset mid-operation, including mid-DELAY or mid-transfer: immediately return to reset values. No further sccb_start until a new start.
- An entry of 16'hFFF0 at address 0 is legal: delay first, no write issued.

Test Plan:
1. ROM {1280, FFF0, 1214, FFFF}, DELAY_CYCLES=8, SCCB model with 20-cycle transfers, pulse start.
   -> Two sccb_start pulses: (reg 12, data 80) then (reg 12, data 14).
   -> The second write is separated from the first completion by >= 8 idle cycles.
   -> done=1, busy=0, wr_count=2, rom_addr=3.
2. ROM entry 0 = FFFF -> done rises 3 cycles after start; no sccb_start; wr_count=0.
3. sccb_ready held low for 50 cycles while in ISSUE -> no sccb_start until ready=1; sccb_reg and sccb_data stable throughout.
4. ROM with no FFFF (all 256 entries 0x0102) -> exactly 256 sccb_start requests issued; wr_count=255 (saturated); done=1; rom_addr=255; no wrap to 0.
5. Assert rst during the 2nd write's WAIT_CMP -> all outputs return to reset values asynchronously; no sccb_start after reset deasserts. A new start replays the table from address 0.
6. start pulsed while busy, then again after done -> the busy pulse has no effect; the post-done start reruns the table and produces an identical write sequence.
